// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE,
    DATA_BUSY,
    FETCH_BUSY
  } arbState_t;

  localparam int MEM_LAT_DEF = 2;
endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data requesters.
// Data wins ties; one access in flight; stall freezes the pipeline.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  arbState_t     state;
  logic [CW-1:0] cnt;
  logic          kill;
  logic          isStore;
  logic          done;

  assign done = (cnt == '0);

  always_comb begin
    if_rdata  = '0;
    if_valid  = 1'b0;
    d_rdata   = '0;
    d_valid   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (Reset) begin
      unique case (state)
        IDLE: begin
          if (d_req) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else if (if_req) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
        DATA_BUSY: begin
          if (done) begin
            d_valid = 1'b1;
            // a store ack carries no read data
            d_rdata = isStore ? '0 : mem_rdata;
          end
        end
        FETCH_BUSY: begin
          if (done && !kill && !if_kill) begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall = Reset &
    ((if_req & ~if_valid) | (d_req & ~d_valid));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      kill    <= 1'b0;
      isStore <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          kill <= 1'b0;
          if (d_req) begin
            state   <= DATA_BUSY;
            cnt     <= CNT_INIT;
            isStore <= d_we;
          end else if (if_req) begin
            state   <= FETCH_BUSY;
            cnt     <= CNT_INIT;
            isStore <= 1'b0;
          end
        end
        DATA_BUSY: begin
          if (done) state <= IDLE;
          else      cnt   <= cnt - CW'(1);
        end
        FETCH_BUSY: begin
          if (done) begin
            state <= IDLE;
            kill  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (if_kill) kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter (MEM_LAT=2 and MEM_LAT=1).
module tb_mem_port_arbiter;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct {
    string       name;
    bit          rst;
    bit          ifReq;
    logic [31:0] ifAddr;
    bit          ifKill;
    bit          dReq;
    bit          dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] memRdata;
    bit          memEn;
    bit          memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    bit          ifValid;
    logic [31:0] ifRdata;
    bit          dValid;
    logic [31:0] dRdata;
    bit          stall;
  } vec_t;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic if_req = 1'b0, if_kill = 1'b0;
  logic d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0, mem_rdata = '0;

  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_valid, d_valid, stall, mem_en, mem_we;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic if_valid1, d_valid1, stall1, mem_en1, mem_we1;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dutL1 (
    .clk(clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata1), .if_valid(if_valid1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_valid(d_valid1), .stall(stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata)
  );

  task automatic applyVec(input vec_t v);
    bit ok;
    @(negedge clk);
    Reset = v.rst;
    if_req = v.ifReq;
    if_addr = v.ifAddr;
    if_kill = v.ifKill;
    d_req = v.dReq;
    d_we = v.dWe;
    d_addr = v.dAddr;
    d_wdata = v.dWdata;
    mem_rdata = v.memRdata;
    #2;
    ok = (mem_en === v.memEn) && (mem_we === v.memWe) &&
         (mem_addr === v.memAddr) && (mem_wdata === v.memWdata) &&
         (if_valid === v.ifValid) && (if_rdata === v.ifRdata) &&
         (d_valid === v.dValid) && (d_rdata === v.dRdata) &&
         (stall === v.stall);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got en=%b we=%b a=%h wd=%h iv=%b ir=%h dv=%b dr=%h st=%b need en=%b we=%b a=%h wd=%h iv=%b ir=%h dv=%b dr=%h st=%b",
        v.name, mem_en, mem_we, mem_addr, mem_wdata, if_valid, if_rdata,
        d_valid, d_rdata, stall, v.memEn, v.memWe, v.memAddr, v.memWdata,
        v.ifValid, v.ifRdata, v.dValid, v.dRdata, v.stall);
    end
  endtask

  task automatic chkL1(input string name, input bit en, input bit dv,
                       input logic [31:0] a, input logic [31:0] dr);
    total++;
    if (mem_en1 !== en || d_valid1 !== dv || mem_addr1 !== a ||
        d_rdata1 !== dr) begin
      bad++;
      $display("FAIL %s: got en=%b dv=%b a=%h dr=%h need en=%b dv=%b a=%h dr=%h",
        name, mem_en1, d_valid1, mem_addr1, d_rdata1, en, dv, a, dr);
    end
  endtask

  initial begin
    // name, rst, ifReq, ifAddr, ifKill, dReq, dWe, dAddr, dWdata, memRdata |
    // memEn, memWe, memAddr, memWdata, ifValid, ifRdata, dValid, dRdata, stall
    vecs.push_back('{"rst_state", L, H, 32'h10, L, H, L, 32'h44, Z, 32'h1111,
      L, L, Z, Z, L, Z, L, Z, L});
    vecs.push_back('{"rst_issue_d", H, L, Z, L, H, L, 32'h44, Z, 32'h1111,
      H, L, 32'h44, Z, L, Z, L, Z, H});
    vecs.push_back('{"rst_mid_busy", L, L, Z, L, H, L, 32'h44, Z, 32'h1111,
      L, L, Z, Z, L, Z, L, Z, L});
    vecs.push_back('{"rst_if_issue", H, H, 32'h10, L, L, L, Z, Z, 32'h2222,
      H, L, 32'h10, Z, L, Z, L, Z, H});
    vecs.push_back('{"rst_if_wait", H, H, 32'h10, L, L, L, Z, Z, 32'h2222,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"rst_if_done", H, H, 32'h10, L, L, L, Z, Z, 32'h2222,
      L, L, Z, Z, H, 32'h2222, L, Z, L});
    vecs.push_back('{"idle_quiet", H, L, Z, L, L, L, Z, Z, 32'h9999,
      L, L, Z, Z, L, Z, L, Z, L});
    vecs.push_back('{"fetch_issue", H, H, 32'h4, L, L, L, Z, Z, 32'h8C220000,
      H, L, 32'h4, Z, L, Z, L, Z, H});
    vecs.push_back('{"fetch_wait", H, H, 32'h4, L, L, L, Z, Z, 32'h8C220000,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"fetch_done", H, H, 32'h4, L, L, L, Z, Z, 32'h8C220000,
      L, L, Z, Z, H, 32'h8C220000, L, Z, L});
    vecs.push_back('{"cont_issue", H, H, 32'h8, L, H, L, 32'h40, Z, 32'h33330000,
      H, L, 32'h40, Z, L, Z, L, Z, H});
    vecs.push_back('{"cont_wait", H, H, 32'h8, L, H, L, 32'h40, Z, 32'h33330000,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"cont_d_done", H, H, 32'h8, L, H, L, 32'h40, Z, 32'h33330000,
      L, L, Z, Z, L, Z, H, 32'h33330000, H});
    vecs.push_back('{"cont_if_issue", H, H, 32'h8, L, L, L, Z, Z, 32'h44440000,
      H, L, 32'h8, Z, L, Z, L, Z, H});
    vecs.push_back('{"cont_if_wait", H, H, 32'h8, L, L, L, Z, Z, 32'h44440000,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"cont_if_done", H, H, 32'h8, L, L, L, Z, Z, 32'h44440000,
      L, L, Z, Z, H, 32'h44440000, L, Z, L});
    vecs.push_back('{"st_issue", H, L, Z, L, H, H, 32'h20, 32'hDEADBEEF,
      32'h77777777, H, H, 32'h20, 32'hDEADBEEF, L, Z, L, Z, H});
    vecs.push_back('{"st_wait", H, L, Z, L, H, H, 32'h20, 32'hDEADBEEF,
      32'h77777777, L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"st_ack", H, L, Z, L, H, H, 32'h20, 32'hDEADBEEF,
      32'h77777777, L, L, Z, Z, L, Z, H, Z, L});
    vecs.push_back('{"kill_issue", H, H, 32'hC, L, L, L, Z, Z, 32'h5555,
      H, L, 32'hC, Z, L, Z, L, Z, H});
    vecs.push_back('{"kill_mid", H, H, 32'hC, H, L, L, Z, Z, 32'h5555,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"kill_done", H, H, 32'hC, L, L, L, Z, Z, 32'h5555,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"kill_reissue", H, H, 32'h100, L, L, L, Z, Z, 32'h6666,
      H, L, 32'h100, Z, L, Z, L, Z, H});
    vecs.push_back('{"kill_re_wait", H, H, 32'h100, L, L, L, Z, Z, 32'h6666,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"kill_re_done", H, H, 32'h100, L, L, L, Z, Z, 32'h6666,
      L, L, Z, Z, H, 32'h6666, L, Z, L});
    vecs.push_back('{"kill_in_idle", H, L, Z, H, L, L, Z, Z, 32'h9999,
      L, L, Z, Z, L, Z, L, Z, L});
    vecs.push_back('{"killc_issue", H, H, 32'h14, L, L, L, Z, Z, 32'hA,
      H, L, 32'h14, Z, L, Z, L, Z, H});
    vecs.push_back('{"killc_wait", H, H, 32'h14, L, L, L, Z, Z, 32'hA,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"killc_done", H, H, 32'h14, H, L, L, Z, Z, 32'hA,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"killc_idle", H, L, Z, L, L, L, Z, Z, 32'hA,
      L, L, Z, Z, L, Z, L, Z, L});
    vecs.push_back('{"postkill_issue", H, H, 32'h18, L, L, L, Z, Z, 32'hB,
      H, L, 32'h18, Z, L, Z, L, Z, H});
    vecs.push_back('{"postkill_wait", H, H, 32'h18, L, L, L, Z, Z, 32'hB,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"postkill_done", H, H, 32'h18, L, L, L, Z, Z, 32'hB,
      L, L, Z, Z, H, 32'hB, L, Z, L});
    vecs.push_back('{"dkill_issue", H, L, Z, L, H, L, 32'h30, Z, 32'hC0,
      H, L, 32'h30, Z, L, Z, L, Z, H});
    vecs.push_back('{"dkill_mid", H, L, Z, H, H, L, 32'h30, Z, 32'hC0,
      L, L, Z, Z, L, Z, L, Z, H});
    vecs.push_back('{"dkill_done", H, L, Z, H, H, L, 32'h30, Z, 32'hC0,
      L, L, Z, Z, L, Z, H, 32'hC0, L});

    repeat (2) @(negedge clk);
    foreach (vecs[i]) applyVec(vecs[i]);

    // MEM_LAT=1: back-to-back loads, completion in the cycle after issue
    @(negedge clk);
    Reset = 1'b0;
    if_req = 1'b0;
    if_kill = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1;
      d_addr = 32'h200 + 32'(4 * k);
      mem_rdata = 32'hF000 + 32'(k);
      #2;
      chkL1($sformatf("lat1_issue%0d", k), H, L, d_addr, Z);
      @(negedge clk);
      #2;
      chkL1($sformatf("lat1_done%0d", k), L, H, Z, 32'hF000 + 32'(k));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
